// File: rtl/fetch_decode_stage.sv
// Front-end fetch/decode stage: fetches, decodes, reads operands, hands off to execute.
// Optional illegal-opcode trap enabled by defining DECODE_ILLEGAL_TRAP_EN.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          REG_AW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  output logic [REG_AW-1:0] rf_rd,
  input  logic [31:0]       rf_x_rs1,
  input  logic [31:0]       rf_x_rs2,
  input  logic [31:0]       rf_x_rd,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [31:0]       wb_data,
  output logic              de_valid,
  input  logic              de_ready,
  output logic [31:0]       de_pc,
  output logic [3:0]        de_opcode,
  output logic [3:0]        de_opt,
  output logic [REG_AW-1:0] de_rd,
  output logic [REG_AW-1:0] de_rs1,
  output logic [REG_AW-1:0] de_rs2,
  output logic [31:0]       de_imm16,
  output logic [31:0]       de_x_rd,
  output logic [31:0]       de_x_rs1,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic              de_illegal,
`endif
  output logic [31:0]       de_x_rs2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DROP
`ifdef DECODE_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] addr_q;
  logic        cap;

  assign rf_rd  = imem_rdata[8 +: REG_AW];
  assign rf_rs1 = imem_rdata[12 +: REG_AW];
  assign rf_rs2 = imem_rdata[16 +: REG_AW];

  assign imem_req  = (state == S_FETCH) || (state == S_DROP);
  assign imem_addr = addr_q;
  assign de_valid  = (state == S_HOLD);

  // Next-state, next-pc and capture decision; redirect overrides all.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cap     = 1'b0;
    unique case (state)
      S_IDLE:  state_n = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          pc_n    = pc + 32'd4;
          cap     = 1'b1;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (de_ready) begin
          state_n = S_FETCH;
`ifdef DECODE_ILLEGAL_TRAP_EN
          if (de_illegal) state_n = S_HALT;
`endif
        end
      end
      S_DROP: begin
        if (imem_ack) state_n = S_FETCH;
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      S_HALT:  state_n = S_HALT;
`endif
      default: state_n = S_IDLE;
    endcase
    if (redirect_valid) begin
      pc_n = redirect_pc;
      cap  = 1'b0;
      if ((state == S_FETCH || state == S_DROP) && !imem_ack)
        state_n = S_DROP;
      else
        state_n = S_FETCH;
    end
  end

  // State, pc and the fetch address; the address freezes while a
  // request is being dropped so the memory side sees a stable request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (state_n != S_DROP) addr_q <= pc_n;
    end
  end

  // Decode record: capture with write-back bypass, then forward while held.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_pc     <= '0;
      de_opcode <= '0;
      de_opt    <= '0;
      de_rd     <= '0;
      de_rs1    <= '0;
      de_rs2    <= '0;
      de_imm16  <= '0;
      de_x_rd   <= '0;
      de_x_rs1  <= '0;
      de_x_rs2  <= '0;
    end else if (cap) begin
      de_pc     <= pc;
      de_opcode <= imem_rdata[3:0];
      de_opt    <= imem_rdata[7:4];
      de_rd     <= rf_rd;
      de_rs1    <= rf_rs1;
      de_rs2    <= rf_rs2;
      de_imm16  <= {{16{imem_rdata[31]}}, imem_rdata[31:16]};
      de_x_rd   <= (wb_en && wb_rd == rf_rd)  ? wb_data : rf_x_rd;
      de_x_rs1  <= (wb_en && wb_rd == rf_rs1) ? wb_data : rf_x_rs1;
      de_x_rs2  <= (wb_en && wb_rd == rf_rs2) ? wb_data : rf_x_rs2;
    end else if (state == S_HOLD && wb_en) begin
      if (wb_rd == de_rd)  de_x_rd  <= wb_data;
      if (wb_rd == de_rs1) de_x_rs1 <= wb_data;
      if (wb_rd == de_rs2) de_x_rs2 <= wb_data;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Flag opcodes beyond the implemented set at capture time.
  always_ff @(posedge clk) begin
    if (reset)    de_illegal <= 1'b0;
    else if (cap) de_illegal <= (imem_rdata[3:0] > 4'h6);
  end
`endif

endmodule
